// File: rtl/stack_ram_responder_pkg.sv
// Shared types and default widths for the stack RAM responder.
package stack_pkg;

  localparam int DW_DEF = 10;
  localparam int AW_DEF = 8;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_LOAD = 2'b11
  } stack_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WR   = 2'b01,
    ST_RD   = 2'b10,
    ST_RSP  = 2'b11
  } stack_state_t;

endpackage

// File: rtl/stack_ram_responder_if.sv
// Request/response bus between the control unit and the stack responder.
interface stack_ram_responder_if
  import stack_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
);

  logic          req_valid;
  logic          req_ready;
  stack_op_t     req_op;
  logic [DW-1:0] req_data;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] sp;
  logic          empty;
  logic          full;
  logic          err_ovf;
  logic          err_unf;

  modport master (
    output req_valid, req_op, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, sp, empty, full, err_ovf, err_unf
  );

  modport slave (
    input  req_valid, req_op, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data, sp, empty, full, err_ovf, err_unf
  );

endinterface

// File: rtl/stack_ram_responder_ram.sv
// Single-port stack storage, synchronous write and read, shaped for block RAM.
module stack_ram #(
  parameter int DW = 10,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/stack_ram_responder.sv
// Stack responder: serves PUSH/POP/LOAD over valid/ready, owns pointer and storage.
// Optional overflow/underflow guard enabled by defining STACK_GUARD_EN.
module stack_ram_responder
  import stack_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  stack_ram_responder_if.slave   bus
);

  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  stack_state_t  state;
  logic [AW-1:0] sp;
  logic [AW:0]   occ;
  logic          req_ready;
  logic          rsp_valid;
  logic [DW-1:0] rsp_data;
  logic          guard_p;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata;
  logic          empty;
  logic          full;
  logic          accept;
  logic          guard_hit;
  logic          we;
  logic          re;

  assign empty  = (occ == '0);
  assign full   = (occ == DEPTH);
  assign accept = bus.req_valid && req_ready;

  // Gating with rst_n keeps a reset landing on WR/RD from touching the RAM.
  assign we = rst_n && (state == ST_WR) && !guard_p;
  assign re = rst_n && (state == ST_RD) && !guard_p;

`ifdef STACK_GUARD_EN
  logic err_ovf;
  logic err_unf;

  assign guard_hit = ((bus.req_op == OP_PUSH) && full) ||
                     ((bus.req_op == OP_POP) && empty);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (accept && guard_hit) begin
      if (bus.req_op == OP_PUSH) err_ovf <= 1'b1;
      else                       err_unf <= 1'b1;
    end
  end

  assign bus.err_ovf = err_ovf;
  assign bus.err_unf = err_unf;
`else
  assign guard_hit   = 1'b0;
  assign bus.err_ovf = 1'b0;
  assign bus.err_unf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      sp        <= '0;
      occ       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      guard_p   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            guard_p <= guard_hit;
            case (bus.req_op)
              OP_PUSH: begin
                req_ready <= 1'b0;
                state     <= ST_WR;
                if (!guard_hit) begin
                  sp <= sp - 1'b1;
                  if (!full) occ <= occ + 1'b1;
                end
              end
              OP_POP: begin
                req_ready <= 1'b0;
                state     <= ST_RD;
                if (!guard_hit) begin
                  sp <= sp + 1'b1;
                  if (!empty) occ <= occ - 1'b1;
                end
              end
              OP_LOAD: begin
                sp  <= bus.req_data[AW-1:0];
                occ <= '0;
              end
              default: ;
            endcase
          end
        end
        ST_WR: begin
          state     <= ST_IDLE;
          req_ready <= 1'b1;
        end
        ST_RD: state <= ST_RSP;
        ST_RSP: begin
          // First RSP cycle captures the RAM output; then hold until consumed.
          if (!rsp_valid) begin
            rsp_valid <= 1'b1;
            rsp_data  <= guard_p ? '0 : rdata;
          end else if (bus.rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
            req_ready <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Address and write data are only consumed in WR/RD, so they need no reset.
  always_ff @(posedge clk) begin
    if (accept && (bus.req_op == OP_PUSH)) begin
      mem_addr <= sp - 1'b1;
      wdata    <= bus.req_data;
    end else if (accept && (bus.req_op == OP_POP)) begin
      mem_addr <= sp;
    end
  end

  stack_ram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .we    (we),
    .re    (re),
    .addr  (mem_addr),
    .wdata (wdata),
    .rdata (rdata)
  );

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_data  = rsp_data;
  assign bus.sp        = sp;
  assign bus.empty     = empty;
  assign bus.full      = full;

endmodule
